clk_div_ctrl: RTL and testbench

Runtime-programmable clock divider with a round-robin arbiter that shares divider reconfiguration among `N_REQ` requesters. Each requester asks for a new half-period count. The controller grants one request at a time and applies it only at a half-period boundary, so `clk_out` never shows a runt pulse. It sits between `clk_in` and the low-rate logic (display refresh, debouncers, blinkers), which needs its rate changed at run time by several masters.

---
 rtl/clk_div_pkg.sv | 22 ++
 rtl/clk_div_ctrl_tick_div.sv | 58 +++++
 rtl/clk_div_ctrl.sv | 122 ++++++++++++
 tb/tb_clk_div_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types, constants and helpers for the runtime-programmable clock divider.
//   ctrl_state_t : controller FSM state (IDLE / PEND)
//   clamp_div    : maps a requested half-period of 0 to 1
//   DEF_*        : default parameter values (1 Hz from 100 MHz)
package clk_div_pkg;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_CNT_W = 27;
    localparam int unsigned DEF_DIV   = 50_000_000;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } ctrl_state_t;

    // A half-period of zero would never reach a boundary; treat it as 1.
    // Operates on 32 bits, so CNT_W must not exceed 32.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/clk_div_ctrl_tick_div.sv
// Half-period counter producing clk_out and a toggle tick.
// Ports:
//   clk_in, reset          : clock, synchronous active-high reset
//   load_i, new_div_i      : new half-period, applied only at a boundary
//   boundary_c             : combinational, counter is at cur_div-1 this cycle
//   clk_out_o, tick_o      : divided clock and one-cycle toggle pulse (registered)
//   cur_div_o              : half-period in force (registered)
module tick_div
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] new_div_i,
    output logic             boundary_c,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic [CNT_W-1:0] cur_div_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    assign boundary_c = (cnt_q == (div_q - CNT_W'(1)));

    // New divider value and counter restart land on the same edge, so the
    // counter can never run past the new cur_div-1.
    always_comb begin
        cnt_d  = boundary_c ? '0 : (cnt_q + CNT_W'(1));
        clk_d  = boundary_c ? ~clk_q : clk_q;
        tick_d = boundary_c;
        div_d  = (boundary_c && load_i) ? new_div_i : div_q;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_q  <= '0;
            div_q  <= CNT_W'(DEFAULT_DIV);
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;
    assign cur_div_o = div_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock divider whose half-period is reprogrammed by N_REQ requesters through
// a round-robin arbiter; changes take effect only at a half-period boundary.
// Ports:
//   clk_in, reset : clock, synchronous active-high reset
//   req, div_req  : per-requester level request and requested half-period
//   grant         : one-hot pulse when the requester's value takes effect
//   clk_out, tick : divided clock and per-toggle pulse
//   cur_div       : half-period in force
//   busy          : a latched request is pending
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned N_REQ       = DEF_N_REQ,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] div_req,
    output logic [N_REQ-1:0]       grant,
    output logic                   clk_out,
    output logic                   tick,
    output logic [CNT_W-1:0]       cur_div,
    output logic                   busy
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    ctrl_state_t      state_q, state_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             busy_q, busy_d;

    logic [IDX_W-1:0] sel_idx_c;
    logic [CNT_W-1:0] sel_div_c;
    logic             found_c;
    logic             boundary_c;
    logic             load_c;

    // Round-robin pick: first asserted req scanning upward from rr_q.
    always_comb begin
        sel_idx_c = rr_q;
        found_c   = 1'b0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (!found_c && req[(int'(rr_q) + k) % int'(N_REQ)]) begin
                found_c   = 1'b1;
                sel_idx_c = IDX_W'((int'(rr_q) + k) % int'(N_REQ));
            end
        end
        sel_div_c = CNT_W'(clamp_div(32'(div_req[int'(sel_idx_c)*int'(CNT_W) +: CNT_W])));
    end

    // Controller next-state and outputs. Load happens only from PEND, so a
    // request latched on a boundary cycle waits for the following boundary.
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        rr_d       = rr_q;
        pend_div_d = pend_div_q;
        grant_d    = '0;
        load_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (found_c) begin
                    win_d      = sel_idx_c;
                    pend_div_d = sel_div_c;
                    state_d    = PEND;
                end
            end
            PEND: begin
                if (boundary_c) begin
                    load_c         = 1'b1;
                    grant_d[win_q] = 1'b1;
                    rr_d           = (win_q == IDX_W'(N_REQ - 1)) ? '0 : (win_q + IDX_W'(1));
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Held through the grant cycle, dropping one cycle later.
        busy_d = (state_d == PEND) || (state_q == PEND);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= IDLE;
            win_q      <= '0;
            rr_q       <= '0;
            pend_div_q <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            rr_q       <= rr_d;
            pend_div_q <= pend_div_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
        end
    end

    tick_div #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_tick_div (
        .clk_in     (clk_in),
        .reset      (reset),
        .load_i     (load_c),
        .new_div_i  (pend_div_q),
        .boundary_c (boundary_c),
        .clk_out_o  (clk_out),
        .tick_o     (tick),
        .cur_div_o  (cur_div)
    );

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl (N_REQ=4, CNT_W=8, DEFAULT_DIV=4).
module tb_clk_div_ctrl;

    localparam int unsigned N_REQ       = 4;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned DEFAULT_DIV = 4;

    logic                   clk_in = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] div_req;
    logic [N_REQ-1:0]       grant;
    logic                   clk_out;
    logic                   tick;
    logic [CNT_W-1:0]       cur_div;
    logic                   busy;

    typedef struct {
        int idx;
        int div;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    clk_div_ctrl #(
        .N_REQ       (N_REQ),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .req     (req),
        .div_req (div_req),
        .grant   (grant),
        .clk_out (clk_out),
        .tick    (tick),
        .cur_div (cur_div),
        .busy    (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_div(input int i, input int v);
        div_req[i*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    task automatic wait_grant(input int budget, output bit got, output int cycles);
        got    = 1'b0;
        cycles = 0;
        while (!got && cycles < budget) begin
            step();
            cycles++;
            if (grant !== '0) got = 1'b1;
        end
    endtask

    // Pops one scoreboard entry and compares the grant cycle against it.
    task automatic score_grant(input string name, input bit got);
        exp_t             e;
        logic [N_REQ-1:0] eg;
        n_total++;
        if (!got) begin
            $display("FAIL %s_timeout: no grant seen, queue depth %0d", name, sb_q.size());
            return;
        end
        if (sb_q.size() == 0) begin
            $display("FAIL %s_unexpected: grant %b with empty scoreboard", name, grant);
            return;
        end
        n_pass++;
        e  = sb_q.pop_front();
        eg = N_REQ'(1) << e.idx;
        n_total++;
        if (grant !== eg) $display("FAIL %s_grant: got %b want %b", name, grant, eg);
        else n_pass++;
        n_total++;
        if (cur_div !== CNT_W'(e.div)) $display("FAIL %s_cur_div: got %0d want %0d", name, cur_div, e.div);
        else n_pass++;
        n_total++;
        if (tick !== 1'b1) $display("FAIL %s_tick_coincident: got %b want 1", name, tick);
        else n_pass++;
        req[e.idx] = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] exp_tc;
        reset   = 1'b1;
        req     = '0;
        div_req = '0;
        repeat (3) step();
        n_total++; if (clk_out !== 1'b0) $display("FAIL reset_clk_out: got %b want 0", clk_out); else n_pass++;
        n_total++; if (tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", tick); else n_pass++;
        n_total++; if (grant !== '0) $display("FAIL reset_grant: got %b want 0", grant); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (cur_div !== 8'd4) $display("FAIL reset_cur_div: got %0d want 4", cur_div); else n_pass++;
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            exp_tc = {(i % 4) == 0, ((i / 4) % 2) == 1};
            n_total++;
            if ({tick, clk_out} !== exp_tc)
                $display("FAIL freerun_cycle%0d: tick/clk_out got %b want %b", i, {tick, clk_out}, exp_tc);
            else n_pass++;
        end
        n_total++; if (busy !== 1'b0) $display("FAIL freerun_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_boundary_latch();
        bit got;
        int cyc;
        repeat (3) step();
        set_div(0, 3);
        req[0] = 1'b1;
        sb_q.push_back('{0, 3});
        step();
        n_total++; if (tick !== 1'b1) $display("FAIL bnd_tick: got %b want 1", tick); else n_pass++;
        n_total++; if (grant !== '0) $display("FAIL bnd_same_edge_grant: got %b want 0", grant); else n_pass++;
        n_total++; if (cur_div !== 8'd4) $display("FAIL bnd_cur_div: got %0d want 4", cur_div); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL bnd_busy: got %b want 1", busy); else n_pass++;
        wait_grant(12, got, cyc);
        n_total++; if (cyc !== 4) $display("FAIL bnd_latency: got %0d want 4", cyc); else n_pass++;
        score_grant("bnd", got);
    endtask

    task automatic test_single();
        bit got;
        int cyc;
        set_div(0, 2);
        req[0] = 1'b1;
        sb_q.push_back('{0, 2});
        wait_grant(12, got, cyc);
        n_total++; if (busy !== 1'b1) $display("FAIL single_busy_at_grant: got %b want 1", busy); else n_pass++;
        score_grant("single", got);
        for (int i = 1; i <= 4; i++) begin
            step();
            n_total++;
            if (tick !== ((i % 2) == 0)) $display("FAIL single_period_c%0d: tick got %b want %b", i, tick, (i % 2) == 0);
            else n_pass++;
            if (i == 1) begin
                n_total++; if (busy !== 1'b0) $display("FAIL single_busy_drop: got %b want 0", busy); else n_pass++;
            end
        end
    endtask

    task automatic test_round_robin();
        bit got;
        int cyc;
        set_div(1, 3);
        set_div(3, 5);
        req = 4'b1010;
        sb_q.push_back('{1, 3});
        sb_q.push_back('{3, 5});
        repeat (2) begin
            wait_grant(20, got, cyc);
            score_grant("rr_a", got);
        end
        // Pointer now wraps to 0, so requester 0 beats requester 3.
        set_div(0, 4);
        set_div(3, 6);
        req = 4'b1001;
        sb_q.push_back('{0, 4});
        sb_q.push_back('{3, 6});
        repeat (2) begin
            wait_grant(20, got, cyc);
            score_grant("rr_b", got);
        end
    endtask

    task automatic test_clamp();
        bit   got;
        int   cyc;
        logic prev;
        set_div(2, 0);
        req = 4'b0100;
        sb_q.push_back('{2, 1});
        wait_grant(20, got, cyc);
        score_grant("clamp", got);
        prev = clk_out;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_total++;
            if ({tick, clk_out} !== {1'b1, ~prev})
                $display("FAIL clamp_toggle_c%0d: tick/clk_out got %b want %b", i, {tick, clk_out}, {1'b1, ~prev});
            else n_pass++;
            prev = ~prev;
        end
    endtask

    task automatic test_commit();
        bit got;
        int cyc;
        set_div(1, 6);
        req = 4'b0010;
        sb_q.push_back('{1, 6});
        step();
        n_total++; if (busy !== 1'b1) $display("FAIL commit_busy: got %b want 1", busy); else n_pass++;
        n_total++; if (grant !== '0) $display("FAIL commit_early_grant: got %b want 0", grant); else n_pass++;
        req = '0;
        set_div(1, 9);
        wait_grant(12, got, cyc);
        score_grant("commit", got);
    endtask

    task automatic test_reset_mid();
        set_div(3, 2);
        req = 4'b1000;
        step();
        n_total++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy); else n_pass++;
        reset = 1'b1;
        req   = '0;
        step();
        n_total++; if (grant !== '0) $display("FAIL rstmid_grant: got %b want 0", grant); else n_pass++;
        n_total++; if (cur_div !== 8'd4) $display("FAIL rstmid_cur_div: got %0d want 4", cur_div); else n_pass++;
        n_total++; if (clk_out !== 1'b0) $display("FAIL rstmid_clk_out: got %b want 0", clk_out); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            n_total++;
            if ({grant, tick} !== {4'b0000, (i % 4) == 0})
                $display("FAIL rstmid_after_c%0d: grant/tick got %b want %b", i, {grant, tick}, {4'b0000, (i % 4) == 0});
            else n_pass++;
        end
        n_total++; if (sb_q.size() !== 0) $display("FAIL sb_leftover: got %0d want 0", sb_q.size()); else n_pass++;
    endtask

    initial begin
        reset   = 1'b1;
        req     = '0;
        div_req = '0;
        test_reset();
        test_boundary_latch();
        test_single();
        test_round_robin();
        test_clamp();
        test_commit();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
